// File: rtl/alu_exec_unit.sv
// Execute stage: single-cycle RV32I ALU ops plus an iterative multiply/divide unit.
// Requests use a start/ready/done handshake so the controller can stall on long ops.
module alu_exec_unit #(
  parameter int WIDTH  = 32,
  parameter bit MDU_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       ALU_op,
  input  logic [2:0]       f3,
  input  logic [6:0]       f7,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             done,
  output logic             illegal
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {S_IDLE, S_ITER} state_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
    OP_OR, OP_AND, OP_MUL, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_t;

  state_t           state_q, state_d;
  op_t              mop_q, mop_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] origA_q, origA_d;
  logic             negQ_q, negQ_d;
  logic             negR_q, negR_d;
  logic             divZero_q, divZero_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             illegal_q, illegal_d;

  op_t              opKind;
  logic             opLegal;
  logic             opMulti;
  logic             opSigned;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] singleRes;
  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;

  logic [WIDTH:0]   mulSum;
  logic [WIDTH-1:0] mulHi;
  logic [WIDTH-1:0] mulLo;
  logic [WIDTH:0]   divTmp;
  logic             divGe;
  logic [WIDTH-1:0] divHi;
  logic [WIDTH-1:0] divLo;
  logic [WIDTH-1:0] finalRes;

  function automatic op_t baseOp(input logic [2:0] fn);
    case (fn)
      3'b000:  return OP_ADD;
      3'b001:  return OP_SLL;
      3'b010:  return OP_SLT;
      3'b011:  return OP_SLTU;
      3'b100:  return OP_XOR;
      3'b101:  return OP_SRL;
      3'b110:  return OP_OR;
      default: return OP_AND;
    endcase
  endfunction

  // Translate the controller's ALU_op/f3/f7 into a single operation code.
  always_comb begin
    opKind  = OP_ADD;
    opLegal = 1'b1;
    case (ALU_op)
      2'b00: opKind = OP_ADD;
      2'b01: opKind = OP_SUB;
      2'b10: begin
        if (f7 == 7'b0000000) begin
          opKind = baseOp(f3);
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          opKind = OP_SUB;
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          opKind = OP_SRA;
        end else if (MDU_EN && f7 == 7'b0000001) begin
          case (f3)
            3'b000:  opKind = OP_MUL;
            3'b011:  opKind = OP_MULHU;
            3'b100:  opKind = OP_DIV;
            3'b101:  opKind = OP_DIVU;
            3'b110:  opKind = OP_REM;
            3'b111:  opKind = OP_REMU;
            default: opLegal = 1'b0;
          endcase
        end else begin
          opLegal = 1'b0;
        end
      end
      default: begin
        case (f3)
          3'b001: begin
            if (f7 == 7'b0000000) opKind = OP_SLL;
            else                  opLegal = 1'b0;
          end
          3'b101: begin
            if (f7 == 7'b0000000)      opKind = OP_SRL;
            else if (f7 == 7'b0100000) opKind = OP_SRA;
            else                       opLegal = 1'b0;
          end
          default: opKind = baseOp(f3);
        endcase
      end
    endcase
  end

  assign opMulti  = opKind inside {OP_MUL, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign opSigned = (opKind == OP_DIV) || (opKind == OP_REM);
  assign shamt    = b[SW-1:0];
  assign absA     = (opSigned && a[WIDTH-1]) ? -a : a;
  assign absB     = (opSigned && b[WIDTH-1]) ? -b : b;

  always_comb begin
    singleRes = '0;
    case (opKind)
      OP_ADD:  singleRes = a + b;
      OP_SUB:  singleRes = a - b;
      OP_SLL:  singleRes = a << shamt;
      OP_SLT:  singleRes = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: singleRes = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_XOR:  singleRes = a ^ b;
      OP_SRL:  singleRes = a >> shamt;
      OP_SRA:  singleRes = $signed(a) >>> shamt;
      OP_OR:   singleRes = a | b;
      OP_AND:  singleRes = a & b;
      default: singleRes = '0;
    endcase
  end

  // One iteration step; hi/lo hold partial product or remainder/quotient.
  always_comb begin
    mulSum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : {WIDTH{1'b0}})};
    mulHi  = mulSum[WIDTH:1];
    mulLo  = {mulSum[0], lo_q[WIDTH-1:1]};
    divTmp = {hi_q, lo_q[WIDTH-1]};
    divGe  = divTmp >= {1'b0, opnd_q};
    divHi  = divGe ? (divTmp[WIDTH-1:0] - opnd_q) : divTmp[WIDTH-1:0];
    divLo  = {lo_q[WIDTH-2:0], divGe};
  end

  always_comb begin
    finalRes = '0;
    case (mop_q)
      OP_MUL:   finalRes = mulLo;
      OP_MULHU: finalRes = mulHi;
      OP_DIV, OP_DIVU: begin
        if (divZero_q)   finalRes = '1;
        else if (ovf_q)  finalRes = origA_q;
        else if (negQ_q) finalRes = -divLo;
        else             finalRes = divLo;
      end
      OP_REM, OP_REMU: begin
        if (divZero_q)   finalRes = origA_q;
        else if (ovf_q)  finalRes = '0;
        else if (negR_q) finalRes = -divHi;
        else             finalRes = divHi;
      end
      default: finalRes = '0;
    endcase
  end

  // Next-state and handshake logic.
  always_comb begin
    state_d   = state_q;
    mop_d     = mop_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    origA_d   = origA_q;
    negQ_d    = negQ_q;
    negR_d    = negR_q;
    divZero_d = divZero_q;
    ovf_d     = ovf_q;
    result_d  = result_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!opLegal) begin
            result_d  = '0;
            illegal_d = 1'b1;
            done_d    = 1'b1;
          end else if (opMulti) begin
            state_d   = S_ITER;
            mop_d     = opKind;
            cnt_d     = CW'(WIDTH);
            hi_d      = '0;
            origA_d   = a;
            negQ_d    = opSigned && (a[WIDTH-1] ^ b[WIDTH-1]);
            negR_d    = opSigned && a[WIDTH-1];
            divZero_d = (b == '0);
            ovf_d     = opSigned && (a == MIN_VAL) && (b == '1);
            if (opKind == OP_MUL || opKind == OP_MULHU) begin
              lo_d   = b;
              opnd_d = a;
            end else begin
              lo_d   = absA;
              opnd_d = absB;
            end
          end else begin
            result_d = singleRes;
            done_d   = 1'b1;
          end
        end
      end
      default: begin
        cnt_d = cnt_q - CW'(1);
        if (mop_q == OP_MUL || mop_q == OP_MULHU) begin
          hi_d = mulHi;
          lo_d = mulLo;
        end else begin
          hi_d = divHi;
          lo_d = divLo;
        end
        if (cnt_q == CW'(1)) begin
          result_d = finalRes;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mop_q     <= OP_ADD;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      origA_q   <= '0;
      negQ_q    <= 1'b0;
      negR_q    <= 1'b0;
      divZero_q <= 1'b0;
      ovf_q     <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mop_q     <= mop_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opnd_q    <= opnd_d;
      origA_q   <= origA_d;
      negQ_q    <= negQ_d;
      negR_q    <= negR_d;
      divZero_q <= divZero_d;
      ovf_q     <= ovf_d;
      result_q  <= result_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  assign ready   = (state_q == S_IDLE);
  assign result  = result_q;
  assign zero    = (result_q == '0);
  assign done    = done_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus random requests
// compared against an arithmetic reference model; a second instance has the MDU disabled.
module tb_alu_exec_unit;

  localparam int W = 32;

  logic          clk;
  logic          rst;
  logic          start;
  logic [1:0]    ALU_op;
  logic [2:0]    f3;
  logic [6:0]    f7;
  logic [W-1:0]  a;
  logic [W-1:0]  b;

  logic          ready, zero, done, illegal;
  logic [W-1:0]  result;
  logic          ready0, zero0, done0, illegal0;
  logic [W-1:0]  result0;

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(.WIDTH(W), .MDU_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .ALU_op(ALU_op), .f3(f3), .f7(f7),
    .a(a), .b(b), .ready(ready), .result(result), .zero(zero), .done(done),
    .illegal(illegal)
  );

  alu_exec_unit #(.WIDTH(W), .MDU_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .ALU_op(ALU_op), .f3(f3), .f7(f7),
    .a(a), .b(b), .ready(ready0), .result(result0), .zero(zero0), .done(done0),
    .illegal(illegal0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain arithmetic from the instruction semantics.
  function automatic logic [W-1:0] basicAlu(input logic [2:0] fn, input logic [W-1:0] x,
                                            input logic [W-1:0] y);
    int unsigned sh;
    sh = y % W;
    case (fn)
      3'd0:    return x + y;
      3'd1:    return x << sh;
      3'd2:    return ($signed(x) < $signed(y)) ? 1 : 0;
      3'd3:    return (x < y) ? 1 : 0;
      3'd4:    return x ^ y;
      3'd5:    return x >> sh;
      3'd6:    return x | y;
      default: return x & y;
    endcase
  endfunction

  function automatic logic [W-1:0] mduRef(input logic [2:0] fn, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    logic [2*W-1:0] prod;
    logic           ovf;
    prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    ovf  = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (fn)
      3'd0:    return prod[W-1:0];
      3'd3:    return prod[2*W-1:W];
      3'd4:    return (y == 0) ? 32'hFFFF_FFFF : ovf ? x : W'($signed(x) / $signed(y));
      3'd5:    return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6:    return (y == 0) ? x : ovf ? 0 : W'($signed(x) % $signed(y));
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  task automatic refModel(input logic [1:0] op, input logic [2:0] fn3, input logic [6:0] fn7,
                          input logic [W-1:0] x, input logic [W-1:0] y, input bit mduEn,
                          output bit legal, output bit multi, output logic [W-1:0] res);
    legal = 1;
    multi = 0;
    res   = 0;
    if (op == 2'b00) res = x + y;
    else if (op == 2'b01) res = x - y;
    else if (op == 2'b10) begin
      if (fn7 == 7'h00) res = basicAlu(fn3, x, y);
      else if (fn7 == 7'h20 && fn3 == 3'd0) res = x - y;
      else if (fn7 == 7'h20 && fn3 == 3'd5) res = $signed(x) >>> (y % W);
      else if (fn7 == 7'h01 && mduEn && fn3 != 3'd1 && fn3 != 3'd2) begin
        multi = 1;
        res   = mduRef(fn3, x, y);
      end else legal = 0;
    end else begin
      if (fn3 == 3'd1 && fn7 != 7'h00) legal = 0;
      else if (fn3 == 3'd5 && fn7 == 7'h20) res = $signed(x) >>> (y % W);
      else if (fn3 == 3'd5 && fn7 != 7'h00) legal = 0;
      else res = basicAlu(fn3, x, y);
    end
    if (!legal) res = 0;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and follow it to its done pulse, checking latency and outputs.
  task automatic applyStimulus(input logic [1:0] op, input logic [2:0] fn3, input logic [6:0] fn7,
                               input logic [W-1:0] x, input logic [W-1:0] y, input string tag,
                               output logic [W-1:0] expOut);
    bit legal, multi, legal0, multi0;
    logic [W-1:0] exp, exp0;
    int lat, lowCnt;
    refModel(op, fn3, fn7, x, y, 1'b1, legal, multi, exp);
    refModel(op, fn3, fn7, x, y, 1'b0, legal0, multi0, exp0);
    ALU_op = op; f3 = fn3; f7 = fn7; a = x; b = y; start = 1'b1;
    checkOutput({tag, "/ready_before"}, 64'(ready), 64'(1));
    stepCycle();
    start = 1'b0;
    checkOutput({tag, "/mduoff_done"}, 64'(done0), 64'(1));
    checkOutput({tag, "/mduoff_illegal"}, 64'(illegal0), 64'(!legal0));
    checkOutput({tag, "/mduoff_result"}, 64'(result0), 64'(exp0));
    lat = 1;
    lowCnt = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (ready === 1'b0) lowCnt++;
      stepCycle();
      lat++;
    end
    checkOutput({tag, "/latency"}, 64'(lat), multi ? 64'(W + 1) : 64'(1));
    checkOutput({tag, "/ready_low_cycles"}, 64'(lowCnt), multi ? 64'(W) : 64'(0));
    checkOutput({tag, "/result"}, 64'(result), 64'(exp));
    checkOutput({tag, "/illegal"}, 64'(illegal), 64'(!legal));
    checkOutput({tag, "/zero"}, 64'(zero), 64'(exp == 0));
    checkOutput({tag, "/ready_at_done"}, 64'(ready), 64'(1));
    expOut = exp;
  endtask

  task automatic idleCheck(input logic [W-1:0] held, input string tag);
    start = 1'b0;
    stepCycle();
    checkOutput({tag, "/done_single_pulse"}, 64'(done), 64'(0));
    checkOutput({tag, "/result_held"}, 64'(result), 64'(held));
  endtask

  function automatic logic [W-1:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin : stimulus
    logic [W-1:0] r;
    logic [W-1:0] mulExp;
    int pulses;
    logic [W-1:0] seen;
    bit lg, ml;
    rst = 1'b1; start = 1'b0; ALU_op = '0; f3 = '0; f7 = '0; a = '0; b = '0;
    stepCycle();
    stepCycle();
    checkOutput("reset/result", 64'(result), 64'(0));
    checkOutput("reset/zero", 64'(zero), 64'(1));
    checkOutput("reset/done", 64'(done), 64'(0));
    checkOutput("reset/illegal", 64'(illegal), 64'(0));
    checkOutput("reset/ready", 64'(ready), 64'(1));
    rst = 1'b0;

    applyStimulus(2'b00, 3'd0, 7'h00, 32'd5, 32'd3, "add_5_3", r);
    checkOutput("add_5_3/const", 64'(r), 64'(8));
    applyStimulus(2'b01, 3'd0, 7'h00, 32'd3, 32'd3, "sub_3_3", r);
    applyStimulus(2'b01, 3'd0, 7'h00, 32'd9, 32'd4, "sub_9_4", r);

    applyStimulus(2'b10, 3'd0, 7'h01, 32'd7, 32'hFFFF_FFFD, "mul", r);
    checkOutput("mul/const", 64'(r), 64'h0000_0000_FFFF_FFEB);
    idleCheck(r, "mul");
    applyStimulus(2'b10, 3'd3, 7'h01, 32'd7, 32'hFFFF_FFFD, "mulhu", r);
    checkOutput("mulhu/const", 64'(r), 64'(6));

    applyStimulus(2'b10, 3'd4, 7'h01, -32'sd7, 32'd2, "div_neg", r);
    checkOutput("div_neg/const", 64'(r), 64'h0000_0000_FFFF_FFFD);
    applyStimulus(2'b10, 3'd6, 7'h01, -32'sd7, 32'd2, "rem_neg", r);
    checkOutput("rem_neg/const", 64'(r), 64'h0000_0000_FFFF_FFFF);
    applyStimulus(2'b10, 3'd4, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", r);
    applyStimulus(2'b10, 3'd6, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf", r);
    applyStimulus(2'b10, 3'd5, 7'h01, 32'd5, 32'd0, "divu_zero", r);
    applyStimulus(2'b10, 3'd7, 7'h01, 32'd5, 32'd0, "remu_zero", r);
    applyStimulus(2'b10, 3'd4, 7'h01, -32'sd9, 32'd0, "div_zero_signed", r);

    applyStimulus(2'b11, 3'd5, 7'h20, 32'h8000_0000, 32'd4, "srai", r);
    checkOutput("srai/const", 64'(r), 64'h0000_0000_F800_0000);
    applyStimulus(2'b10, 3'd7, 7'h20, 32'd1, 32'd1, "rtype_bad_f7", r);
    applyStimulus(2'b10, 3'd1, 7'h01, 32'd1, 32'd1, "mdu_f3_001", r);
    applyStimulus(2'b11, 3'd1, 7'h20, 32'd1, 32'd1, "slli_bad_f7", r);

    // Start pulse during ITER must be dropped: exactly one done, carrying the MUL result.
    refModel(2'b10, 3'd0, 7'h01, 32'd12345, 32'd678, 1'b1, lg, ml, mulExp);
    ALU_op = 2'b10; f3 = 3'd0; f7 = 7'h01; a = 32'd12345; b = 32'd678; start = 1'b1;
    stepCycle();
    start = 1'b0;
    repeat (5) stepCycle();
    ALU_op = 2'b00; a = 32'd1; b = 32'd1; start = 1'b1;
    stepCycle();
    start = 1'b0;
    pulses = 0;
    seen = '0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin
        pulses++;
        seen = result;
      end
      stepCycle();
    end
    checkOutput("ignored_start/pulses", 64'(pulses), 64'(1));
    checkOutput("ignored_start/result", 64'(seen), 64'(mulExp));

    // Reset ten cycles into a DIVU aborts it without a done pulse.
    ALU_op = 2'b10; f3 = 3'd5; f7 = 7'h01; a = 32'd1000; b = 32'd7; start = 1'b1;
    stepCycle();
    start = 1'b0;
    repeat (9) stepCycle();
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    checkOutput("mid_reset/ready", 64'(ready), 64'(1));
    checkOutput("mid_reset/done", 64'(done), 64'(0));
    checkOutput("mid_reset/result", 64'(result), 64'(0));
    checkOutput("mid_reset/zero", 64'(zero), 64'(1));
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) pulses++;
      stepCycle();
    end
    checkOutput("mid_reset/no_done", 64'(pulses), 64'(0));

    for (int i = 0; i < 40; i++) begin
      logic [1:0] rop;
      logic [2:0] rf3;
      logic [6:0] rf7;
      rop = 2'($urandom_range(0, 3));
      rf3 = 3'($urandom);
      case ($urandom_range(0, 3))
        0:       rf7 = 7'h00;
        1:       rf7 = 7'h20;
        2:       rf7 = 7'h01;
        default: rf7 = 7'($urandom);
      endcase
      applyStimulus(rop, rf3, rf7, pickOperand(), pickOperand(), $sformatf("rand%0d", i), r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised execute stage that merges ALU-control decoding with a registered integer datapath. It adds RV32I shifts and the M-extension multiply/divide group, executed iteratively over multiple cycles. It sits between the controller (which supplies `ALU_op`, `f3`, `f7`) and the register-file/writeback path, and uses a start/ready/done handshake so the multi-cycle controller can stall on long operations.

## Interface
- `WIDTH`, 32: operand/result width; power of two, at least 8.
- `MDU_EN`, 1: when 1, `f7=0000001` R-type ops execute; when 0 they are illegal.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in WIDTH=1: request valid; accepted on an edge where `start && ready`.
- `ALU_op` in 2: 00 add, 01 sub, 10 R-type (decode `f7`,`f3`), 11 I-type (decode `f3`, and `f7` for shifts).
- `f3` in 3: funct3.
- `f7` in 7: funct7.
- `a` in WIDTH: operand A (rs1).
- `b` in WIDTH: operand B (rs2 or immediate).
- `ready` out 1: high in IDLE only.
- `result` out WIDTH: registered result, held until the next completion.
- `zero` out 1: `result == 0`.
- `done` out 1: one-cycle completion pulse.
- `illegal` out 1: qualifies `done`; high for an undecodable request.

## Operation
- FSM states are IDLE and ITER.
- **IDLE:** `ready=1`.
  - On accept of a single-cycle op: write `result` and set `done=1`; stay in IDLE. Back-to-back requests sustain one op per cycle.
  - On accept of MUL/DIV: latch operands and op, load the counter with WIDTH, and go to ITER.
- **ITER:** `ready=0`.
  - One shift-add step (multiply) or one restoring-division step (divide) per cycle; the counter decrements each step.
  - On the final step: write `result`, set `done=1`, return to IDLE.
  - `start` is ignored while `ready=0`, and the request is not queued.
- **Single-cycle ops:**
  - ADD, SUB; SLL/SRL/SRA with shift amount `b[log2(WIDTH)-1:0]`.
  - SLT (signed) and SLTU produce 1 or 0, zero-extended.
  - XOR, OR, AND.
  - I-type `f3` 001 requires `f7=0000000`. I-type `f3` 101 requires `f7` of 0000000 (SRL) or 0100000 (SRA).
- **R-type decode `{f7,f3}`:** all RV32I combinations; with `f7=0000001`: 000 MUL (low half), 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- **Unsupported R-type M codes:** `f7=0000001` with `f3` 001 or 010 is illegal.
- **Signed DIV/REM:** operate on magnitudes; negate the quotient if the signs differ, and negate the remainder if `a` is negative.
- **Divide by zero:** quotient is all ones, remainder is `a`.
- **Signed overflow** (`a=100..0`, `b=all ones`): quotient is `a`, remainder is 0.
- Both divide special cases still take full ITER latency.
- **Illegal request:** single-cycle completion with `done=1`, `illegal=1`, `result=0`. Previous result is not held.
- `illegal` is 0 on every legal completion.
- **Reset:** valid in any state, including mid-ITER. It aborts the operation with no `done` pulse; the state becomes IDLE.

## Timing
- **Reset values:** `result=0`, `zero=1`, `done=0`, `illegal=0`, `ready=1`; counter 0.
- **Single-cycle op accepted at edge k:** `done`, `result`, and `illegal` are valid in cycle k+1.
- **MUL/DIV accepted at edge k:** `ready=0` in cycles k+1..k+WIDTH; `done` and `result` are valid in cycle k+WIDTH+1, and `ready=1` in that same cycle.
- A new request may be accepted in the `done` cycle.
- `done` is never high for two consecutive cycles from the same request.
- `result` does not change between completions.

## Test plan
- **Basic ops:** `rst` then ADD `a=5`, `b=3` -> `result=8`, `done` one cycle later. Then back-to-back SUB 3-3 -> `result=0`, `zero=1`, and `done` stays high across consecutive cycles.
- **MUL (WIDTH=32):** `a=7`, `b=0xFFFFFFFD` -> `result=0xFFFFFFEB`, `done` 33 cycles after accept, `ready=0` for 32 cycles. MULHU on the same operands -> `result=0x00000006`.
- **Signed divide:** DIV `-7/2` -> `0xFFFFFFFD`; REM -> `0xFFFFFFFF`. Overflow DIV `0x80000000/0xFFFFFFFF` -> `0x80000000`; REM -> 0.
- **Divide by zero:** DIVU `5/0` -> `0xFFFFFFFF`; REMU `5/0` -> `5`; both take the full 33-cycle latency.
- **Shift and illegal decode:** I-type SRA `a=0x80000000`, `b=4`, `f7=0100000` -> `0xF8000000`. R-type `f7=0100000`, `f3=111` -> `illegal=1`, `result=0`. With `MDU_EN=0`, MUL -> `illegal=1`.
- **Reset mid-operation and ignored start:** assert `rst` 10 cycles into a DIVU -> no `done` pulse, `ready=1`, `result=0`. Pulse `start` during ITER -> request ignored, exactly one `done` pulse.
